// File: rtl/instr_encoder.sv
// instr_encoder: encodes ALU requests into R-type words and buffers them in a DEPTH-entry FIFO
module instr_encoder #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [2:0]                 req_op,
  input  logic [4:0]                 req_rs,
  input  logic [4:0]                 req_rt,
  input  logic [4:0]                 req_rd,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [31:0]                instr,
  output logic                       err,
  output logic [$clog2(DEPTH):0]     count,
  output logic [15:0]                issued
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [5:0] func;
  logic legal, acc, push, pop;
  always_comb begin
    func  = req_op == 3'd0 ? 6'b000001 :
            req_op == 3'd1 ? 6'b010001 :
            req_op == 3'd2 ? 6'b001001 :
            req_op == 3'd3 ? 6'b101001 : 6'b010101;
    legal = req_op < 3'd5;
    acc   = req_valid && req_ready;
    push  = acc && legal;
    pop   = instr_valid && instr_ready;
  end
  assign req_ready   = count < (AW+1)'(DEPTH);
  assign instr_valid = count != '0;
  assign instr       = instr_valid ? mem[rp] : '0;
  always_ff @(posedge clk)
    if (push) mem[wp] <= {6'b0, req_rs, req_rt, req_rd, 5'b0, func};
  always_ff @(posedge clk) begin
    if (rst) begin
      wp     <= '0;
      rp     <= '0;
      count  <= '0;
      err    <= 1'b0;
      issued <= '0;
    end else begin
      wp     <= wp + AW'(push);
      rp     <= rp + AW'(pop);
      count  <= count + (AW+1)'(push) - (AW+1)'(pop);
      err    <= acc && !legal;
      issued <= issued + 16'(pop);
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed self-checking bench for instr_encoder
module tb_instr_encoder;
  logic clk = 1'b0;
  logic rst, req_valid, req_ready, instr_valid, instr_ready, err;
  logic [2:0] req_op;
  logic [4:0] req_rs, req_rt, req_rd;
  logic [31:0] instr;
  logic [2:0] count;
  logic [15:0] issued;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  instr_encoder #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .err(err), .count(count), .issued(issued)
  );
  function automatic logic [31:0] enc(input logic [2:0] op, input logic [4:0] rs, rt, rd);
    logic [5:0] f;
    f = op == 3'd0 ? 6'b000001 :
        op == 3'd1 ? 6'b010001 :
        op == 3'd2 ? 6'b001001 :
        op == 3'd3 ? 6'b101001 : 6'b010101;
    return {6'b000000, rs, rt, rd, 5'b00000, f};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic req(input logic v, input logic [2:0] op, input logic [4:0] rs, rt, rd);
    req_valid = v;
    req_op = op;
    req_rs = rs;
    req_rt = rt;
    req_rd = rd;
  endtask
  initial begin
    rst = 1'b1;
    instr_ready = 1'b0;
    req(1'b0, 3'd0, 5'd0, 5'd0, 5'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_issued", 32'(issued), 32'd0);
    req(1'b1, 3'd2, 5'd3, 5'd4, 5'd5);
    instr_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("one_valid", 32'(instr_valid), 32'd1);
    chk("one_instr", instr, 32'h00642809);
    chk("one_count", 32'(count), 32'd1);
    @(negedge clk);
    chk("one_issued", 32'(issued), 32'd1);
    chk("one_empty_instr", instr, 32'd0);
    chk("one_empty_count", 32'(count), 32'd0);
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req(1'b1, 3'(i), 5'(i + 1), 5'(i + 2), 5'(i + 3));
      @(negedge clk);
    end
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(req_ready), 32'd0);
    chk("full_head", instr, enc(3'd0, 5'd1, 5'd2, 5'd3));
    req(1'b1, 3'd4, 5'd9, 5'd10, 5'd11);
    @(negedge clk);
    chk("full_reject_count", 32'(count), 32'd4);
    chk("stall_head", instr, enc(3'd0, 5'd1, 5'd2, 5'd3));
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    chk("fullpop_count", 32'(count), 32'd3);
    chk("fullpop_head", instr, enc(3'd1, 5'd2, 5'd3, 5'd4));
    chk("fullpop_issued", 32'(issued), 32'd2);
    chk("fullpop_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("refill_count", 32'(count), 32'd4);
    instr_ready = 1'b1;
    chk("drain0", instr, enc(3'd1, 5'd2, 5'd3, 5'd4));
    @(negedge clk);
    chk("drain1", instr, enc(3'd2, 5'd3, 5'd4, 5'd5));
    @(negedge clk);
    chk("drain2", instr, enc(3'd3, 5'd4, 5'd5, 5'd6));
    @(negedge clk);
    chk("drain3", instr, enc(3'd4, 5'd9, 5'd10, 5'd11));
    @(negedge clk);
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_issued", 32'(issued), 32'd6);
    instr_ready = 1'b0;
    req(1'b1, 3'd6, 5'd7, 5'd8, 5'd9);
    chk("ill_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_count", 32'(count), 32'd0);
    chk("ill_valid", 32'(instr_valid), 32'd0);
    chk("ill_issued", 32'(issued), 32'd6);
    chk("ill_ready_after", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("ill_err_pulse", 32'(err), 32'd0);
    instr_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      req(1'b1, 3'(k % 5), 5'(k), 5'(k + 1), 5'(31 - k));
      @(negedge clk);
      chk($sformatf("stream%0d", k), instr, enc(3'(k % 5), 5'(k), 5'(k + 1), 5'(31 - k)));
      chk($sformatf("stream%0d_count", k), 32'(count), 32'd1);
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("stream_issued", 32'(issued), 32'd16);
    chk("stream_count", 32'(count), 32'd0);
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req(1'b1, 3'(i), 5'(i), 5'(i), 5'(i));
      @(negedge clk);
    end
    chk("pre_rst_count", 32'(count), 32'd3);
    req(1'b1, 3'd7, 5'd1, 5'd1, 5'd1);
    instr_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b0;
    instr_ready = 1'b0;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_valid", 32'(instr_valid), 32'd0);
    chk("mid_rst_instr", instr, 32'd0);
    chk("mid_rst_issued", 32'(issued), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
